// File: rtl/cmac_link_supervisor_if.sv
// -----------------------------------------------------------------------------
// cmac_link_supervisor_if
//
// Purpose:
//   Groups the control and status signals exchanged between the CMAC link
//   supervisor and the CMAC core / status logic.
//
// Signals:
//   rx_aligned          : CMAC stat_rx_aligned, synchronous to the user clock
//   ctl_rx_enable       : CMAC RX enable
//   ctl_tx_enable       : CMAC TX enable
//   ctl_tx_send_lfi     : transmit local fault indication
//   ctl_tx_send_rfi     : transmit remote fault indication
//   ctl_rx_force_resync : RX resynchronisation pulse
//   rx_reset            : RX reset pulse
//   link_up             : link declared up
//   link_down_count     : saturating count of link drops
//   state_out           : supervisor state encoding for ILA/status
//
// Modports:
//   master : the supervisor (drives controls/status, samples rx_aligned)
//   slave  : the CMAC/status side (drives rx_aligned, samples the rest)
// -----------------------------------------------------------------------------
interface cmac_link_supervisor_if;
  logic        rx_aligned;
  logic        ctl_rx_enable;
  logic        ctl_tx_enable;
  logic        ctl_tx_send_lfi;
  logic        ctl_tx_send_rfi;
  logic        ctl_rx_force_resync;
  logic        rx_reset;
  logic        link_up;
  logic [15:0] link_down_count;
  logic [2:0]  state_out;

  modport master (
    input  rx_aligned,
    output ctl_rx_enable,
    output ctl_tx_enable,
    output ctl_tx_send_lfi,
    output ctl_tx_send_rfi,
    output ctl_rx_force_resync,
    output rx_reset,
    output link_up,
    output link_down_count,
    output state_out
  );

  modport slave (
    output rx_aligned,
    input  ctl_rx_enable,
    input  ctl_tx_enable,
    input  ctl_tx_send_lfi,
    input  ctl_tx_send_rfi,
    input  ctl_rx_force_resync,
    input  rx_reset,
    input  link_up,
    input  link_down_count,
    input  state_out
  );
endinterface

// File: rtl/cmac_link_supervisor.sv
// -----------------------------------------------------------------------------
// cmac_link_supervisor
//
// Purpose:
//   Link bring-up and recovery controller for one CMAC instance. Enables RX,
//   sends LFI/RFI until alignment is debounced, then enables TX. While the
//   link is down it retries with ctl_rx_force_resync pulses on alignment
//   timeout and escalates to an rx_reset pulse after MAX_RETRIES failed
//   attempts. Link drops are counted (saturating) for status registers.
//
// Ports:
//   clk : CMAC user clock, all logic on the rising edge
//   rst : asynchronous, active-high reset
//   lnk : cmac_link_supervisor_if.master (rx_aligned in, controls/status out)
//
// All outputs are registered and decoded from the next state, so they change
// on the same edge as the state register with no combinational path from
// rx_aligned.
// -----------------------------------------------------------------------------
module cmac_link_supervisor #(
  parameter int unsigned ALIGN_TIMEOUT   = 1000000,
  parameter int unsigned DEBOUNCE_CYCLES = 256,
  parameter int unsigned PULSE_CYCLES    = 16,
  parameter int unsigned MAX_RETRIES     = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  cmac_link_supervisor_if.master        lnk
);

  localparam int unsigned RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [RETRY_W-1:0] RETRY_MAX     = RETRY_W'(MAX_RETRIES);
  localparam logic [31:0]        ALIGN_LAST    = 32'(ALIGN_TIMEOUT - 1);
  localparam logic [31:0]        DEBOUNCE_LAST = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]        PULSE_LAST    = 32'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_ALIGN = 3'd1,
    ST_DEBOUNCE   = 3'd2,
    ST_LINK_UP    = 3'd3,
    ST_RESYNC     = 3'd4,
    ST_RX_RESET   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          timer_q, timer_d;
  logic [RETRY_W-1:0]   retries_q, retries_d;
  logic [15:0]          link_down_count_q, link_down_count_d;

  logic ctl_rx_enable_q,       ctl_rx_enable_d;
  logic ctl_tx_enable_q,       ctl_tx_enable_d;
  logic ctl_tx_send_lfi_q,     ctl_tx_send_lfi_d;
  logic ctl_tx_send_rfi_q,     ctl_tx_send_rfi_d;
  logic ctl_rx_force_resync_q, ctl_rx_force_resync_d;
  logic rx_reset_q,            rx_reset_d;
  logic link_up_q,             link_up_d;

  // Next-state, retry bookkeeping, drop counter and dwell timer.
  always_comb begin
    state_d           = state_q;
    retries_d         = retries_q;
    link_down_count_d = link_down_count_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_WAIT_ALIGN;
      end

      ST_WAIT_ALIGN: begin
        // Alignment wins over a timeout landing on the same cycle.
        if (lnk.rx_aligned) begin
          state_d = ST_DEBOUNCE;
        end else if (timer_q == ALIGN_LAST) begin
          if (retries_q < RETRY_MAX) begin
            state_d   = ST_RESYNC;
            retries_d = retries_q + RETRY_W'(1);
          end else begin
            state_d = ST_RX_RESET;
          end
        end else begin
          state_d = ST_WAIT_ALIGN;
        end
      end

      ST_DEBOUNCE: begin
        // A glitch returns to WAIT_ALIGN without touching the retry budget.
        if (!lnk.rx_aligned) begin
          state_d = ST_WAIT_ALIGN;
        end else if (timer_q == DEBOUNCE_LAST) begin
          state_d   = ST_LINK_UP;
          retries_d = '0;
        end else begin
          state_d = ST_DEBOUNCE;
        end
      end

      ST_LINK_UP: begin
        if (!lnk.rx_aligned) begin
          state_d = ST_WAIT_ALIGN;
          if (link_down_count_q != 16'hFFFF) begin
            link_down_count_d = link_down_count_q + 16'd1;
          end else begin
            link_down_count_d = link_down_count_q;
          end
        end else begin
          state_d = ST_LINK_UP;
        end
      end

      ST_RESYNC: begin
        // rx_aligned is ignored here: the pulse always runs to completion.
        if (timer_q == PULSE_LAST) begin
          state_d = ST_WAIT_ALIGN;
        end else begin
          state_d = ST_RESYNC;
        end
      end

      ST_RX_RESET: begin
        if (timer_q == PULSE_LAST) begin
          state_d   = ST_WAIT_ALIGN;
          retries_d = '0;
        end else begin
          state_d = ST_RX_RESET;
        end
      end

      default: begin
        // Unused encodings 6 and 7 recover through IDLE.
        state_d = ST_IDLE;
      end
    endcase

    // The timer measures dwell time in the current state.
    if (state_d != state_q) begin
      timer_d = 32'd0;
    end else begin
      timer_d = timer_q + 32'd1;
    end
  end

  // Output decode from the next state so outputs register alongside state.
  always_comb begin
    ctl_rx_enable_d       = 1'b0;
    ctl_tx_enable_d       = 1'b0;
    ctl_tx_send_lfi_d     = 1'b0;
    ctl_tx_send_rfi_d     = 1'b0;
    ctl_rx_force_resync_d = 1'b0;
    rx_reset_d            = 1'b0;
    link_up_d             = 1'b0;

    case (state_d)
      ST_IDLE: begin
        ctl_rx_enable_d = 1'b0;
      end

      ST_WAIT_ALIGN, ST_DEBOUNCE: begin
        ctl_rx_enable_d   = 1'b1;
        ctl_tx_send_lfi_d = 1'b1;
        ctl_tx_send_rfi_d = 1'b1;
      end

      ST_LINK_UP: begin
        ctl_rx_enable_d = 1'b1;
        ctl_tx_enable_d = 1'b1;
        link_up_d       = 1'b1;
      end

      ST_RESYNC: begin
        ctl_rx_enable_d       = 1'b1;
        ctl_tx_send_lfi_d     = 1'b1;
        ctl_tx_send_rfi_d     = 1'b1;
        ctl_rx_force_resync_d = 1'b1;
      end

      ST_RX_RESET: begin
        ctl_rx_enable_d   = 1'b1;
        ctl_tx_send_lfi_d = 1'b1;
        ctl_tx_send_rfi_d = 1'b1;
        rx_reset_d        = 1'b1;
      end

      default: begin
        ctl_rx_enable_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q               <= ST_IDLE;
      timer_q               <= 32'd0;
      retries_q             <= '0;
      link_down_count_q     <= 16'd0;
      ctl_rx_enable_q       <= 1'b0;
      ctl_tx_enable_q       <= 1'b0;
      ctl_tx_send_lfi_q     <= 1'b0;
      ctl_tx_send_rfi_q     <= 1'b0;
      ctl_rx_force_resync_q <= 1'b0;
      rx_reset_q            <= 1'b0;
      link_up_q             <= 1'b0;
    end else begin
      state_q               <= state_d;
      timer_q               <= timer_d;
      retries_q             <= retries_d;
      link_down_count_q     <= link_down_count_d;
      ctl_rx_enable_q       <= ctl_rx_enable_d;
      ctl_tx_enable_q       <= ctl_tx_enable_d;
      ctl_tx_send_lfi_q     <= ctl_tx_send_lfi_d;
      ctl_tx_send_rfi_q     <= ctl_tx_send_rfi_d;
      ctl_rx_force_resync_q <= ctl_rx_force_resync_d;
      rx_reset_q            <= rx_reset_d;
      link_up_q             <= link_up_d;
    end
  end

  assign lnk.ctl_rx_enable       = ctl_rx_enable_q;
  assign lnk.ctl_tx_enable       = ctl_tx_enable_q;
  assign lnk.ctl_tx_send_lfi     = ctl_tx_send_lfi_q;
  assign lnk.ctl_tx_send_rfi     = ctl_tx_send_rfi_q;
  assign lnk.ctl_rx_force_resync = ctl_rx_force_resync_q;
  assign lnk.rx_reset            = rx_reset_q;
  assign lnk.link_up             = link_up_q;
  assign lnk.link_down_count     = link_down_count_q;
  assign lnk.state_out           = state_q;

endmodule

// File: tb/tb_cmac_link_supervisor.sv
// -----------------------------------------------------------------------------
// tb_cmac_link_supervisor
//
// Directed bench for cmac_link_supervisor with ALIGN_TIMEOUT=16,
// DEBOUNCE_CYCLES=4, PULSE_CYCLES=4, MAX_RETRIES=2. Inputs change 1 ns after
// the rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_cmac_link_supervisor;

  localparam int unsigned ALIGN_TIMEOUT   = 16;
  localparam int unsigned DEBOUNCE_CYCLES = 4;
  localparam int unsigned PULSE_CYCLES    = 4;
  localparam int unsigned MAX_RETRIES     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fails  = 0;

  cmac_link_supervisor_if lnk_if ();

  cmac_link_supervisor #(
    .ALIGN_TIMEOUT   (ALIGN_TIMEOUT),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .PULSE_CYCLES    (PULSE_CYCLES),
    .MAX_RETRIES     (MAX_RETRIES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .lnk (lnk_if)
  );

  // 100 MHz bench clock.
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks state_out and the full output decode expected for state st.
  // Bit order: rx_en, tx_en, lfi, rfi, resync, rx_reset, link_up.
  task automatic chk_state(input string tag, input logic [2:0] st);
    logic [6:0] exp_v;
    logic [6:0] obs_v;
    logic       fault;
    fault = (st == 3'd1) || (st == 3'd2) || (st == 3'd4) || (st == 3'd5);
    exp_v = {(st != 3'd0), (st == 3'd3), fault, fault,
             (st == 3'd4), (st == 3'd5), (st == 3'd3)};
    obs_v = {lnk_if.ctl_rx_enable, lnk_if.ctl_tx_enable, lnk_if.ctl_tx_send_lfi,
             lnk_if.ctl_tx_send_rfi, lnk_if.ctl_rx_force_resync, lnk_if.rx_reset,
             lnk_if.link_up};
    chk_eq({tag, "_state"}, {29'd0, lnk_if.state_out}, {29'd0, st});
    chk_eq({tag, "_outs"}, {25'd0, obs_v}, {25'd0, exp_v});
  endtask

  // From WAIT_ALIGN with rx_aligned already high: 4 DEBOUNCE cycles then LINK_UP.
  task automatic debounce_to_up(input string tag);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_state({tag, "_deb"}, 3'd2);
    end
    tick();
    chk_state({tag, "_up"}, 3'd3);
  endtask

  logic [2:0] seg_st  [11] = '{3'd1, 3'd4, 3'd1, 3'd4, 3'd1, 3'd5,
                               3'd1, 3'd4, 3'd1, 3'd4, 3'd1};
  int         seg_len [11] = '{16, 4, 16, 4, 16, 4, 16, 4, 16, 4, 16};

  initial begin
    lnk_if.rx_aligned = 1'b0;
    rst               = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 3'd0);
    chk_eq("reset_ldc", {16'd0, lnk_if.link_down_count}, 32'd0);

    // Clean bring-up: cycle 0 is IDLE, WAIT_ALIGN from cycle 1
    @(negedge clk);
    rst = 1'b0;
    chk_state("idle_c0", 3'd0);
    tick();
    chk_state("bringup_c1", 3'd1);
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk_state("bringup_wait", 3'd1);
    end
    lnk_if.rx_aligned = 1'b1;
    debounce_to_up("bringup");

    // Link drops: three drops from LINK_UP
    for (int d = 1; d <= 3; d++) begin
      lnk_if.rx_aligned = 1'b0;
      tick();
      chk_state("drop_down", 3'd1);
      chk_eq("drop_ldc", {16'd0, lnk_if.link_down_count}, d);
      lnk_if.rx_aligned = 1'b1;
      debounce_to_up("drop");
    end

    // Debounce glitch: high 3, low 1, then stable high
    lnk_if.rx_aligned = 1'b0;
    tick();
    chk_state("glitch_pre", 3'd1);
    chk_eq("glitch_ldc", {16'd0, lnk_if.link_down_count}, 32'd4);
    lnk_if.rx_aligned = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("glitch_deb", 3'd2);
    end
    lnk_if.rx_aligned = 1'b0;
    tick();
    chk_state("glitch_back", 3'd1);
    lnk_if.rx_aligned = 1'b1;
    debounce_to_up("glitch");

    // Counter saturation: preload 0xFFFE, then two drops
    @(negedge clk);
    force dut.link_down_count_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.link_down_count_q;
    chk_eq("sat_preload", {16'd0, lnk_if.link_down_count}, 32'h0000_FFFE);
    lnk_if.rx_aligned = 1'b0;
    tick();
    chk_eq("sat_first", {16'd0, lnk_if.link_down_count}, 32'h0000_FFFF);
    lnk_if.rx_aligned = 1'b1;
    debounce_to_up("sat");
    lnk_if.rx_aligned = 1'b0;
    tick();
    chk_eq("sat_second", {16'd0, lnk_if.link_down_count}, 32'h0000_FFFF);

    // Timeout escalation: WAIT 16 / RESYNC 4 / WAIT 16 / RESYNC 4 / WAIT 16 /
    // RX_RESET 4, then the pattern repeats. rx_aligned toggles inside the
    // second RESYNC pulse and must be ignored.
    for (int s = 0; s < 11; s++) begin
      for (int i = 0; i < seg_len[s]; i++) begin
        if (!(s == 0 && i == 0)) begin
          tick();
        end
        chk_state($sformatf("escal_s%0d_i%0d", s, i), seg_st[s]);
        if (s == 3 && i == 0) begin
          lnk_if.rx_aligned = 1'b1;
        end else if (s == 3 && i == 2) begin
          lnk_if.rx_aligned = 1'b0;
        end
      end
    end

    // Async reset in the second cycle of an rx_reset pulse
    tick();
    chk_state("rxr_c1", 3'd5);
    tick();
    chk_state("rxr_c2", 3'd5);
    rst = 1'b1;
    #1;
    chk_state("async_rst", 3'd0);
    chk_eq("async_rst_ldc", {16'd0, lnk_if.link_down_count}, 32'd0);
    tick();
    chk_state("rst_held", 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
